// File: rtl/data_toggle_mc.sv
// Multi-channel read-notification block: per-channel legacy toggle, saturating
// pending counter with valid/ready drain, and sticky overflow behind a read-latency pipe.
module data_toggle_mc #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CH_W     = 2,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned PEND_W   = 3
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     we_b,
    input  logic                     data_toggle_en,
    input  logic [CH_W-1:0]          ch_sel,
    input  logic [NUM_CH-1:0]        data_ready,
    input  logic [NUM_CH-1:0]        clr_ovf,
    output logic [NUM_CH-1:0]        data_toggle,
    output logic [NUM_CH-1:0]        data_valid,
    output logic [NUM_CH*PEND_W-1:0] pend_cnt,
    output logic [NUM_CH-1:0]        ovf
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic              req_c;
    logic              mat_vld;
    logic [CH_W-1:0]   mat_ch;
    logic [PEND_W-1:0] cnt_q [NUM_CH];
    logic [PEND_W-1:0] cnt_d [NUM_CH];
    logic [NUM_CH-1:0] tog_d;
    logic [NUM_CH-1:0] ovf_d;

    assign req_c = !we_b && data_toggle_en && (32'(ch_sel) < NUM_CH);

    // Read-latency pipe; zero stages collapses to the legacy same-edge toggle.
    generate
        if (READ_LAT == 0) begin : g_no_lat
            assign mat_vld = req_c;
            assign mat_ch  = ch_sel;
        end else begin : g_lat
            logic [READ_LAT-1:0] dl_vld;
            logic [CH_W-1:0]     dl_ch [READ_LAT];

            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    dl_vld <= '0;
                    for (int i = 0; i < int'(READ_LAT); i++) dl_ch[i] <= '0;
                end else begin
                    dl_vld[0] <= req_c;
                    dl_ch[0]  <= ch_sel;
                    for (int i = 1; i < int'(READ_LAT); i++) begin
                        dl_vld[i] <= dl_vld[i-1];
                        dl_ch[i]  <= dl_ch[i-1];
                    end
                end
            end

            assign mat_vld = dl_vld[READ_LAT-1];
            assign mat_ch  = dl_ch[READ_LAT-1];
        end
    endgenerate

    // Per-channel next state; a simultaneous increment and drain cancel, even at saturation.
    always_comb begin
        tog_d = data_toggle;
        ovf_d = ovf;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            logic inc;
            logic dec;
            cnt_d[c] = cnt_q[c];
            inc = mat_vld && (mat_ch == CH_W'(c));
            dec = data_valid[c] && data_ready[c];
            if (inc) tog_d[c] = ~data_toggle[c];
            if (inc && !dec) begin
                if (cnt_q[c] == CNT_MAX) cnt_d[c] = cnt_q[c];
                else                     cnt_d[c] = cnt_q[c] + PEND_W'(1);
            end else if (dec && !inc) begin
                cnt_d[c] = cnt_q[c] - PEND_W'(1);
            end
            if (inc && !dec && (cnt_q[c] == CNT_MAX)) ovf_d[c] = 1'b1;
            else if (clr_ovf[c])                       ovf_d[c] = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            data_toggle <= '0;
            ovf         <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) cnt_q[c] <= '0;
        end else begin
            data_toggle <= tog_d;
            ovf         <= ovf_d;
            for (int c = 0; c < int'(NUM_CH); c++) cnt_q[c] <= cnt_d[c];
        end
    end

    generate
        for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_out
            assign pend_cnt[c*PEND_W +: PEND_W] = cnt_q[c];
            assign data_valid[c]                = (cnt_q[c] != '0);
        end
    endgenerate

endmodule

// File: tb/tb_data_toggle_mc.sv
// Bench for data_toggle_mc: two instances (READ_LAT 0 and 3) share stimulus and
// are each checked against a queue-based behavioural model every cycle.
module tb_data_toggle_mc;

    localparam int NCH = 4;
    localparam int CW  = 3;
    localparam int PW  = 3;
    localparam int MAXC = 7;

    logic            Clk = 1'b0;
    logic            Rst;
    logic            we_b;
    logic            data_toggle_en;
    logic [CW-1:0]   ch_sel;
    logic [NCH-1:0]  data_ready;
    logic [NCH-1:0]  clr_ovf;

    logic [NCH-1:0]    tog0, vld0, ovf0;
    logic [NCH*PW-1:0] pc0;
    logic [NCH-1:0]    tog3, vld3, ovf3;
    logic [NCH*PW-1:0] pc3;

    int n_chk = 0;
    int n_bad = 0;

    data_toggle_mc #(.NUM_CH(NCH), .CH_W(CW), .READ_LAT(0), .PEND_W(PW)) u_lat0 (
        .Clk(Clk), .Rst(Rst), .we_b(we_b), .data_toggle_en(data_toggle_en),
        .ch_sel(ch_sel), .data_ready(data_ready), .clr_ovf(clr_ovf),
        .data_toggle(tog0), .data_valid(vld0), .pend_cnt(pc0), .ovf(ovf0));

    data_toggle_mc #(.NUM_CH(NCH), .CH_W(CW), .READ_LAT(3), .PEND_W(PW)) u_lat3 (
        .Clk(Clk), .Rst(Rst), .we_b(we_b), .data_toggle_en(data_toggle_en),
        .ch_sel(ch_sel), .data_ready(data_ready), .clr_ovf(clr_ovf),
        .data_toggle(tog3), .data_valid(vld3), .pend_cnt(pc3), .ovf(ovf3));

    always #5 Clk = ~Clk;

    // Model: index 0 is the READ_LAT=0 instance, index 1 the READ_LAT=3 instance.
    int m_tog [2][NCH];
    int m_cnt [2][NCH];
    int m_ovf [2][NCH];
    int due_q [2][$];
    int chq   [2][$];
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            due_q[d].delete();
            chq[d].delete();
            for (int c = 0; c < NCH; c++) begin
                m_tog[d][c] = 0; m_cnt[d][c] = 0; m_ovf[d][c] = 0;
            end
        end
    endtask

    task automatic model_edge();
        bit req;
        req = !we_b && data_toggle_en && (int'(ch_sel) < NCH);
        for (int d = 0; d < 2; d++) begin
            int lat;
            int mch;
            lat = (d == 0) ? 0 : 3;
            if (req) begin
                due_q[d].push_back(cyc + lat);
                chq[d].push_back(int'(ch_sel));
            end
            mch = -1;
            if (due_q[d].size() > 0 && due_q[d][0] == cyc) begin
                void'(due_q[d].pop_front());
                mch = chq[d].pop_front();
            end
            for (int c = 0; c < NCH; c++) begin
                bit inc, dec, set;
                inc = (mch == c);
                dec = (m_cnt[d][c] != 0) && data_ready[c];
                set = 0;
                if (inc) m_tog[d][c] = 1 - m_tog[d][c];
                if (inc && !dec) begin
                    if (m_cnt[d][c] == MAXC) set = 1;
                    else m_cnt[d][c] = m_cnt[d][c] + 1;
                end else if (dec && !inc) begin
                    m_cnt[d][c] = m_cnt[d][c] - 1;
                end
                if (set) m_ovf[d][c] = 1;
                else if (clr_ovf[c]) m_ovf[d][c] = 0;
            end
        end
        cyc++;
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 2; d++) begin
            logic [31:0] et, ev, eo, ep;
            et = '0; ev = '0; eo = '0; ep = '0;
            for (int c = 0; c < NCH; c++) begin
                et[c] = (m_tog[d][c] != 0);
                ev[c] = (m_cnt[d][c] != 0);
                eo[c] = (m_ovf[d][c] != 0);
                ep = ep | (32'(m_cnt[d][c]) << (c * PW));
            end
            if (d == 0) begin
                check({tag, "_L0_tog"}, 32'(tog0), et);
                check({tag, "_L0_vld"}, 32'(vld0), ev);
                check({tag, "_L0_ovf"}, 32'(ovf0), eo);
                check({tag, "_L0_cnt"}, 32'(pc0), ep);
            end else begin
                check({tag, "_L3_tog"}, 32'(tog3), et);
                check({tag, "_L3_vld"}, 32'(vld3), ev);
                check({tag, "_L3_ovf"}, 32'(ovf3), eo);
                check({tag, "_L3_cnt"}, 32'(pc3), ep);
            end
        end
    endtask

    task automatic step(input string tag, input logic wb, input logic en, input int ch,
                        input logic [NCH-1:0] rdy, input logic [NCH-1:0] clr);
        we_b = wb; data_toggle_en = en; ch_sel = CW'(ch);
        data_ready = rdy; clr_ovf = clr;
        @(posedge Clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 0, '0, '0);
    endtask

    initial begin
        Rst = 1'b0; we_b = 1'b1; data_toggle_en = 1'b0; ch_sel = '0;
        data_ready = '0; clr_ovf = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset");
        Rst = 1'b1;

        // Legacy burst: three reads on channel 0
        step("leg1", 1'b0, 1'b1, 0, '0, '0);
        check("leg_tog_e1", 32'(tog0[0]), 32'd1);
        step("leg2", 1'b0, 1'b1, 0, '0, '0);
        check("leg_tog_e2", 32'(tog0[0]), 32'd0);
        step("leg3", 1'b0, 1'b1, 0, '0, '0);
        check("leg_tog_e3", 32'(tog0[0]), 32'd1);
        check("leg_cnt", 32'(pc0[PW-1:0]), 32'd3);
        check("leg_vld", 32'(vld0[0]), 32'd1);

        // Asynchronous reset mid-burst with reads still in flight in the latency pipe
        step("mid", 1'b0, 1'b1, 2, '0, '0);
        #2 Rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        check("rst_tog3", 32'(tog3), 32'd0);
        @(posedge Clk);
        #1 Rst = 1'b1;
        idle("no_replay", 5);

        // Latency on channel 2
        step("lat_req", 1'b0, 1'b1, 2, '0, '0);
        idle("lat_wait", 2);
        check("lat_early", 32'(tog3), 32'd0);
        idle("lat_mat", 1);
        check("lat_flip", 32'(tog3), 32'b0100);

        // Saturation on channel 1 with no drain
        for (int i = 0; i < 8; i++) step("sat", 1'b0, 1'b1, 1, '0, '0);
        idle("sat_wait", 3);
        check("sat_cnt", 32'(pc3[2*PW-1:PW]), 32'd7);
        check("sat_ovf", 32'(ovf3[1]), 32'd1);
        check("sat_tog", 32'(tog3[1]), 32'd0);
        step("clr", 1'b1, 1'b0, 0, '0, 4'b0010);
        check("clr_ovf", 32'(ovf0[1]), 32'd0);
        step("setclr", 1'b0, 1'b1, 1, '0, 4'b0010);
        check("setclr_ovf", 32'(ovf0[1]), 32'd1);
        idle("setclr_wait", 3);

        // Channel 3 to MAX, then a read matures alongside a drain
        for (int i = 0; i < 7; i++) step("fill3", 1'b0, 1'b1, 3, '0, '0);
        idle("fill3_wait", 3);
        step("incdec", 1'b0, 1'b1, 3, 4'b1000, '0);
        check("incdec_cnt", 32'(pc0[4*PW-1:3*PW]), 32'd7);
        check("incdec_ovf", 32'(ovf0[3]), 32'd0);
        idle("incdec_wait", 3);

        // Ignored accesses
        step("ign_wr", 1'b1, 1'b1, 0, '0, '0);
        step("ign_oor", 1'b0, 1'b1, 5, '0, '0);
        idle("ign_wait", 3);

        // Multi-channel drain
        for (int i = 0; i < 4; i++) step("drain", 1'b1, 1'b0, 0, 4'b1111, '0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            logic [NCH-1:0] rdy, clr;
            for (int c = 0; c < NCH; c++) begin
                rdy[c] = ($urandom_range(0, 99) < 30);
                clr[c] = ($urandom_range(0, 99) < 5);
            end
            step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7),
                 int'($urandom_range(0, 5)), rdy, clr);
        end
        idle("tail", 4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
